// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command set for the 16x2 character LCD refresh path.
// Both the sequencer and the byte writer import this package.
package lcd_pkg;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_ADDR1,
        S_LINE1,
        S_ADDR2,
        S_LINE2,
        S_FEND
    } state_e;

    // Byte writer phases
    typedef enum logic [2:0] {
        W_IDLE,
        W_SETUP,
        W_EN,
        W_WAIT,
        W_DONE
    } wr_state_e;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] DDRAM_L1      = 8'h80;
    localparam logic [7:0] DDRAM_L2      = 8'hC0;

    localparam int LINE_LEN = 16;

    localparam logic [4:0] L1_LAST  = 5'(LINE_LEN - 1);
    localparam logic [4:0] L2_FIRST = 5'(LINE_LEN);
    localparam logic [4:0] L2_LAST  = 5'(2 * LINE_LEN - 1);

    // Power-on init command list, indexed by the init pointer.
    // Pointer value 2 is the clear command and needs the long wait.
    localparam logic [1:0] CLR_PTR  = 2'd2;
    localparam logic [1:0] LAST_PTR = 2'd3;

    function automatic logic [7:0] init_cmd(input logic [1:0] ptr);
        logic [7:0] c;
        c = FUNC_SET_8B2L;
        unique case (ptr)
            2'd0: c = FUNC_SET_8B2L;
            2'd1: c = DISP_ON;
            2'd2: c = CLEAR;
            2'd3: c = ENTRY_INC;
            default: c = FUNC_SET_8B2L;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_writer.sv
// HD44780 single-byte write: drive RS/DATA, setup, E strobe, post-write wait.
// Owns the only timing counter; done pulses one cycle after the wait ends.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 2,
    parameter int EN_HIGH_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       rs_i,
    input  logic       wait_sel_i,
    output logic       done_o,
    output logic       busy_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_en_o
);

    localparam int M1   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int M2   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAXV = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXV + 1);

    wr_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;
    logic           en_q, en_d;
    logic           sel_q, sel_d;
    logic [CW-1:0]  wait_last;

    assign wait_last = sel_q ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

    // Phase register plus the pin-facing registers (async clear drops E at once)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
        end
    end

    // Phase sequencing; bus values only reload on an accepted start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        sel_d   = sel_q;
        unique case (state_q)
            W_IDLE: begin
                if (start_i) begin
                    data_d  = byte_i;
                    rs_d    = rs_i;
                    sel_d   = wait_sel_i;
                    cnt_d   = '0;
                    state_d = W_SETUP;
                end
            end
            W_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = W_EN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            W_EN: begin
                if (cnt_q == CW'(EN_HIGH_CYC - 1)) begin
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    state_d = W_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            W_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d   = '0;
                    state_d = W_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            W_DONE: begin
                state_d = W_IDLE;
            end
            default: begin
                state_d = W_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    assign done_o     = (state_q == W_DONE);
    assign busy_o     = (state_q != W_IDLE);
    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_en_o   = en_q;

    // The sequencer must never request a write while one is in flight
    a_no_start_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(start_i && busy_o)
    );

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 LCD refresh sequencer: power-up delay, init commands, then endless
// line-1/line-2 sweeps of lcd_index, sampling lcd_char for each position.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC  = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int EN_HIGH_CYC  = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] lcd_char,
    output logic [7:0] lcd_index,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       init_done,
    output logic       frame_done
);

    localparam int PW = $clog2(POWERUP_CYC + 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [4:0]    idx_q, idx_d;
    logic          start_q, start_d;
    logic          init_q, init_d;
    logic          fd_q, fd_d;
    logic          on_q;

    logic [7:0]    wr_byte;
    logic          wr_rs;
    logic          wr_sel;
    logic          wr_done;
    logic          wr_busy;

    // Sequencer state and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            pwr_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            init_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pwr_q   <= pwr_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            init_q  <= init_d;
            fd_q    <= fd_d;
        end
    end

    // Panel power comes up on the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q <= 1'b0;
        end else begin
            on_q <= 1'b1;
        end
    end

    // Next state; start is a one-cycle request raised on each transition
    always_comb begin
        state_d = state_q;
        pwr_d   = pwr_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        init_d  = init_q;
        fd_d    = 1'b0;
        unique case (state_q)
            S_PWRUP: begin
                if (pwr_q == PW'(POWERUP_CYC - 1)) begin
                    pwr_d   = '0;
                    ptr_d   = '0;
                    start_d = 1'b1;
                    state_d = S_INIT;
                end else begin
                    pwr_d = pwr_q + 1'b1;
                end
            end
            S_INIT: begin
                if (init_q) begin
                    if (enable) begin
                        idx_d   = '0;
                        start_d = 1'b1;
                        state_d = S_ADDR1;
                    end
                end else if (wr_done) begin
                    if (ptr_q == LAST_PTR) begin
                        init_d = 1'b1;
                        if (enable) begin
                            idx_d   = '0;
                            start_d = 1'b1;
                            state_d = S_ADDR1;
                        end
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        start_d = 1'b1;
                    end
                end
            end
            S_ADDR1: begin
                if (wr_done) begin
                    start_d = 1'b1;
                    state_d = S_LINE1;
                end
            end
            S_LINE1: begin
                if (wr_done) begin
                    start_d = 1'b1;
                    if (idx_q == L1_LAST) begin
                        idx_d   = L2_FIRST;
                        state_d = S_ADDR2;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_ADDR2: begin
                if (wr_done) begin
                    start_d = 1'b1;
                    state_d = S_LINE2;
                end
            end
            S_LINE2: begin
                if (wr_done) begin
                    if (idx_q == L2_LAST) begin
                        idx_d   = '0;
                        fd_d    = 1'b1;
                        state_d = S_FEND;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        start_d = 1'b1;
                    end
                end
            end
            S_FEND: begin
                if (enable) begin
                    idx_d   = '0;
                    start_d = 1'b1;
                    state_d = S_ADDR1;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase
    end

    // Byte/RS/wait selection for the write the current state issues
    always_comb begin
        wr_byte = 8'h00;
        wr_rs   = 1'b0;
        wr_sel  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                wr_byte = init_cmd(ptr_q);
                wr_sel  = (ptr_q == CLR_PTR);
            end
            S_ADDR1: wr_byte = DDRAM_L1;
            S_ADDR2: wr_byte = DDRAM_L2;
            S_LINE1, S_LINE2: begin
                wr_byte = lcd_char;
                wr_rs   = 1'b1;
            end
            default: wr_byte = 8'h00;
        endcase
    end

    lcd_byte_writer #(
        .SETUP_CYC    (SETUP_CYC),
        .EN_HIGH_CYC  (EN_HIGH_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) u_writer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_q),
        .byte_i     (wr_byte),
        .rs_i       (wr_rs),
        .wait_sel_i (wr_sel),
        .done_o     (wr_done),
        .busy_o     (wr_busy),
        .lcd_data_o (lcd_data),
        .lcd_rs_o   (lcd_rs),
        .lcd_en_o   (lcd_en)
    );

    assign lcd_index  = {3'b000, idx_q};
    assign lcd_rw     = 1'b0;
    assign lcd_on     = on_q;
    assign init_done  = init_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Randomised bench for lcd_refresh_ctrl against a write-sequence reference.
// Decodes E strobes into (rs,byte) writes and checks timing per strobe.
module tb_lcd_refresh_ctrl;

    localparam int PWR = 20;
    localparam int S   = 2;
    localparam int H   = 3;
    localparam int CMD = 5;
    localparam int CLR = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] lcd_char;
    logic [7:0] lcd_index;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       init_done;
    logic       frame_done;

    lcd_refresh_ctrl #(
        .POWERUP_CYC  (PWR),
        .SETUP_CYC    (S),
        .EN_HIGH_CYC  (H),
        .CMD_WAIT_CYC (CMD),
        .CLR_WAIT_CYC (CLR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lcd_char   (lcd_char),
        .lcd_index  (lcd_index),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_on     (lcd_on),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign lcd_char = 8'h40 + lcd_index;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write n since reset: 4 init commands, then 34-write frames forever
    function automatic logic [8:0] exp_wr(input int n);
        logic [7:0] init_tab [4];
        int k;
        init_tab = '{8'h38, 8'h0C, 8'h01, 8'h06};
        if (n < 4) return {1'b0, init_tab[n]};
        k = (n - 4) % 34;
        if (k == 0)  return 9'h080;
        if (k <= 16) return {1'b1, 8'(8'h40 + k - 1)};
        if (k == 17) return 9'h0C0;
        return {1'b1, 8'(8'h50 + k - 18)};
    endfunction

    function automatic bit frame_end(input int n);
        return (n >= 4) && (((n - 4) % 34) == 33);
    endfunction

    int         n_wr = 0;
    int         fd_cnt = 0;
    int         cyc = 0;
    int         stab = 0;
    int         hi = 0;
    int         lo = 0;
    bit         prev_clr = 0;
    logic       en_prev = 0;
    logic       fd_prev = 0;
    logic [8:0] key;
    logic [8:0] key_prev = '0;
    logic [8:0] key_rise = '0;

    // Bus monitor: decode strobes, compare to reference, check timing
    always @(negedge clk) begin
        if (!rst_n) begin
            n_wr = 0; cyc = 0; stab = 0; hi = 0; lo = 0;
            en_prev = 0; fd_prev = 0; key_prev = '0;
        end else begin
            cyc++;
            if (cyc == 1) chk("lcd_on", lcd_on, 1);
            chk("rw", lcd_rw, 0);
            chk("idx_max", lcd_index <= 31, 1);
            key = {lcd_rs, lcd_data};
            if (key != key_prev) stab = 1;
            else stab++;
            if (lcd_en && !en_prev) begin
                chk("wr", key, exp_wr(n_wr));
                chk("setup", stab, S + 1);
                chk("init_done", init_done, n_wr >= 4);
                if (n_wr == 0) chk("pwrup", cyc > PWR, 1);
                else if (!frame_end(n_wr - 1))
                    chk("gap", lo, S + 2 + (prev_clr ? CLR : CMD));
                prev_clr = (key == 9'h001);
                key_rise = key;
                hi = 1;
                n_wr++;
            end else if (lcd_en) begin
                chk("hold", key, key_rise);
                hi++;
            end else begin
                if (en_prev) chk("en_high", hi, H);
                lo = en_prev ? 1 : lo + 1;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fd_pulse", fd_prev, 0);
                chk("fd_pos", frame_end(n_wr - 1), 1);
                chk("fd_idx", lcd_index, 0);
            end
            en_prev = lcd_en;
            fd_prev = frame_done;
            key_prev = key;
        end
    end

    task automatic chk_rst(input string t);
        chk({t, "_data"}, lcd_data, 0);
        chk({t, "_rs"}, lcd_rs, 0);
        chk({t, "_en"}, lcd_en, 0);
        chk({t, "_on"}, lcd_on, 0);
        chk({t, "_init"}, init_done, 0);
        chk({t, "_fd"}, frame_done, 0);
        chk({t, "_idx"}, lcd_index, 0);
        chk({t, "_rw"}, lcd_rw, 0);
    endtask

    task automatic wait_fd(input int target, input int lim);
        for (int i = 0; i < lim && fd_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        chk("fd_tmo", fd_cnt >= target, 1);
    endtask

    task automatic wait_rise(input int target, input int lim);
        for (int i = 0; i < lim && n_wr < target; i++) begin
            @(negedge clk); #1;
        end
        chk("rise_tmo", n_wr >= target, 1);
    endtask

    task automatic wait_idx(input int idx, input int lim, input bit need_en);
        bit hit;
        hit = 0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk); #1;
            hit = (lcd_index == 8'(idx)) && (!need_en || lcd_en);
        end
        chk("idx_tmo", hit, 1);
    endtask

    initial begin
        int nf, r, f0, w0;
        rst_n = 0;
        enable = 1;
        repeat (3) @(negedge clk);
        #1 chk_rst("rst0");
        @(negedge clk);
        #2 rst_n = 1;

        // enable wiggles during init must not stop it
        for (int i = 0; i < 400 && n_wr < 4; i++) begin
            @(negedge clk); #1;
            enable = 1'($urandom_range(0, 1));
        end
        enable = 1;
        chk("init_tmo", n_wr >= 4, 1);

        nf = $urandom_range(1, 2);
        wait_fd(fd_cnt + nf, 2000);

        // drop enable mid-frame, first at idx 7 then at a random idx
        for (int t = 0; t < 2; t++) begin
            r = (t == 0) ? 7 : $urandom_range(1, 30);
            wait_idx(r, 1000, 0);
            enable = 0;
            f0 = fd_cnt;
            wait_fd(f0 + 1, 1000);
            w0 = n_wr;
            repeat ($urandom_range(40, 120)) @(negedge clk);
            #1;
            chk("idle_quiet", n_wr, w0);
            chk("idle_fd", fd_cnt, f0 + 1);
            chk("idle_idx", lcd_index, 0);
            enable = 1;
            wait_rise(w0 + 1, 100);
            chk("resume80", key_rise, 9'h080);
        end

        // reset while E is high during idx 20
        wait_idx(20, 1000, 1);
        chk("en_before_rst", lcd_en, 1);
        #2 rst_n = 0;
        #1 chk_rst("rst_mid");
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        wait_rise(6, 600);
        chk("init_again", init_done, 1);
        wait_fd(fd_cnt + 1, 1500);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
